// File: rtl/banco_fifos_salida_if.sv
// -----------------------------------------------------------------------------
// banco_fifos_salida_if
// Bus between the second-stage arbiter / downstream stage (master side) and
// the output FIFO bank (slave side).
//   push               4            write enable, one bit per FIFO
//   data_in            WORD_SIZE    write word (broadcast to every pushed FIFO)
//   pop                4            read request, one bit per FIFO
//   data_out           4*WORD_SIZE  registered read data, FIFO i in slice i
//   fifo_empty         4            occupancy == 0
//   fifo_full          4            occupancy == depth
//   fifos_almost_full  4            occupancy >= almost-full level
//   fifo_almost_empty  4            occupancy <= almost-empty level
//   fifo_error         4            sticky overflow/underflow (0 when disabled)
// -----------------------------------------------------------------------------
interface banco_fifos_salida_if #(
  parameter int WORD_SIZE = 12
);
  logic [3:0]             push;
  logic [WORD_SIZE-1:0]   data_in;
  logic [3:0]             pop;
  logic [4*WORD_SIZE-1:0] data_out;
  logic [3:0]             fifo_empty;
  logic [3:0]             fifo_full;
  logic [3:0]             fifos_almost_full;
  logic [3:0]             fifo_almost_empty;
  logic [3:0]             fifo_error;

  modport master (
    output push, data_in, pop,
    input  data_out, fifo_empty, fifo_full, fifos_almost_full,
           fifo_almost_empty, fifo_error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, fifo_empty, fifo_full, fifos_almost_full,
           fifo_almost_empty, fifo_error
  );
endinterface

// File: rtl/banco_fifos_salida.sv
// -----------------------------------------------------------------------------
// banco_fifos_salida
// Bank of four independent synchronous circular-buffer FIFOs fed by the
// second-stage arbiter. Each FIFO has its own write/read pointers, occupancy
// counter and registered read-data slice; nothing is shared between FIFOs.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    banco_fifos_salida_if.slave (push/data_in/pop in, data and flags out)
//
// Configuration macro: BANCO_FIFOS_ERR_EN
//   defined   -> fifo_error[i] is a sticky overflow/underflow flag
//   undefined -> fifo_error is tied to 0, no error registers exist
// -----------------------------------------------------------------------------
module banco_fifos_salida #(
  parameter int WORD_SIZE        = 12,
  parameter int FIFO_DEPTH       = 8,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input logic                  clk,
  input logic                  reset,
  banco_fifos_salida_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_LVL);

  logic [3:0]                 w_empty;
  logic [3:0]                 w_full;
  logic [3:0]                 w_afull;
  logic [3:0]                 w_aempty;
  logic [3:0]                 w_err;
  logic [3:0][WORD_SIZE-1:0]  w_dout;

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [WORD_SIZE-1:0] r_dout;
    logic                 w_wr;
    logic                 w_rd;

    assign w_empty[g]  = (r_count == '0);
    assign w_full[g]   = (r_count == DEPTH_C);
    assign w_afull[g]  = (r_count >= AF_C);
    assign w_aempty[g] = (r_count <= AE_C);

    // A full FIFO still accepts a push when it is popped on the same edge:
    // the head is read out while the freed slot (same address) is rewritten.
    assign w_wr = bus.push[g] && (!w_full[g] || bus.pop[g]);
    // No fall-through: an empty FIFO never serves a read, even with a push.
    assign w_rd = bus.pop[g] && !w_empty[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_dout  <= '0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        if (w_rd) begin
          r_rptr <= r_rptr + 1'b1;
          r_dout <= r_mem[r_rptr];
        end
        case ({w_wr, w_rd})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= bus.data_in;
    end

    assign w_dout[g] = r_dout;

`ifdef BANCO_FIFOS_ERR_EN
    logic r_err;
    logic w_ovf;
    logic w_unf;

    assign w_ovf = bus.push[g] && w_full[g] && !bus.pop[g];
    assign w_unf = bus.pop[g] && w_empty[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)              r_err <= 1'b0;
      else if (w_ovf || w_unf) r_err <= 1'b1;
    end

    assign w_err[g] = r_err;
`else
    assign w_err[g] = 1'b0;
`endif
  end

  assign bus.data_out          = w_dout;
  assign bus.fifo_empty        = w_empty;
  assign bus.fifo_full         = w_full;
  assign bus.fifos_almost_full = w_afull;
  assign bus.fifo_almost_empty = w_aempty;
  assign bus.fifo_error        = w_err;

endmodule

// File: tb/tb_banco_fifos_salida.sv
// -----------------------------------------------------------------------------
// tb_banco_fifos_salida
// Table-driven bench for banco_fifos_salida: each record holds the inputs for
// one clock edge and the expected read data, per-FIFO occupancy (from which the
// flags follow by their definitions) and expected sticky error vector.
// Reset behaviour is exercised by hand-written sequences around the table.
// -----------------------------------------------------------------------------
module tb_banco_fifos_salida;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  banco_fifos_salida_if #(.WORD_SIZE(12)) bus ();

  banco_fifos_salida #(
    .WORD_SIZE(12), .FIFO_DEPTH(8), .ALMOST_FULL_LVL(6), .ALMOST_EMPTY_LVL(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [11:0]      din;
    logic [47:0]      dout;
    logic [3:0][3:0]  occ;
    logic [3:0]       err;
  } vec_t;

  vec_t vecs[$];

  logic [3:0][11:0] e_dout;
  logic [3:0][3:0]  e_occ;
  logic [3:0]       e_err;

  int total = 0;
  int bad   = 0;

  function void add(input logic [3:0] p, input logic [3:0] q, input logic [11:0] d);
    vec_t v;
    v.push = p;
    v.pop  = q;
    v.din  = d;
    v.dout = e_dout;
    v.occ  = e_occ;
    v.err  = e_err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [47:0] act,
                     input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_vec(input int idx, input logic [47:0] dout,
                         input logic [3:0][3:0] occ, input logic [3:0] err);
    logic [3:0] x_empty, x_full, x_af, x_ae, x_err;
    for (int i = 0; i < 4; i++) begin
      x_empty[i] = (occ[i] == 4'd0);
      x_full[i]  = (occ[i] == 4'd8);
      x_af[i]    = (occ[i] >= 4'd6);
      x_ae[i]    = (occ[i] <= 4'd1);
    end
`ifdef BANCO_FIFOS_ERR_EN
    x_err = err;
`else
    x_err = 4'b0000;
`endif
    chk("data_out",          idx, bus.data_out,                 dout);
    chk("fifo_empty",        idx, 48'(bus.fifo_empty),          48'(x_empty));
    chk("fifo_full",         idx, 48'(bus.fifo_full),           48'(x_full));
    chk("fifos_almost_full", idx, 48'(bus.fifos_almost_full),   48'(x_af));
    chk("fifo_almost_empty", idx, 48'(bus.fifo_almost_empty),   48'(x_ae));
    chk("fifo_error",        idx, 48'(bus.fifo_error),          48'(x_err));
  endtask

  initial begin
    logic [3:0][3:0] z_occ;
    logic [3:0]      e_tmp;

    // ---------------- build the vector table ----------------
    e_dout = '0;
    e_occ  = '0;
    e_err  = '0;

    // FIFO0 filled with 0x001..0x008
    for (int k = 1; k <= 8; k++) begin
      e_occ[0] = 4'(k);
      add(4'b0001, 4'b0000, 12'(k));
    end
    // FIFO0 drained, words come back in order one cycle after each pop
    for (int k = 1; k <= 8; k++) begin
      e_occ[0]  = 4'(8 - k);
      e_dout[0] = 12'(k);
      add(4'b0000, 4'b0001, 12'h000);
    end
    add(4'b0000, 4'b0000, 12'h3C3);                // idle: data_out holds 0x008

    // FIFO1 filled, then overflow push and FIFO3 underflow pop
    for (int k = 1; k <= 8; k++) begin
      e_occ[1] = 4'(k);
      add(4'b0010, 4'b0000, 12'h100 + 12'(k));
    end
    e_err[1] = 1'b1;
    add(4'b0010, 4'b0000, 12'hFFF);                // dropped
    e_err[3] = 1'b1;
    add(4'b0000, 4'b1000, 12'h000);                // ignored
    // push and pop together on the full FIFO1
    e_dout[1] = 12'h101;
    add(4'b0010, 4'b0010, 12'h109);
    for (int k = 2; k <= 9; k++) begin
      e_occ[1]  = 4'(9 - k);
      e_dout[1] = 12'h100 + 12'(k);
      add(4'b0000, 4'b0010, 12'h000);
    end
    // push and pop together on the empty FIFO1: pop ignored, push kept
    e_occ[1] = 4'd1;
    add(4'b0010, 4'b0010, 12'h0AA);
    e_occ[1]  = 4'd0;
    e_dout[1] = 12'h0AA;
    add(4'b0000, 4'b0010, 12'h000);

    // FIFO2 holding 3 words, then 4 cycles of push+pop, then drain
    for (int k = 1; k <= 3; k++) begin
      e_occ[2] = 4'(k);
      add(4'b0100, 4'b0000, 12'h200 + 12'(k));
    end
    for (int k = 1; k <= 4; k++) begin
      e_dout[2] = 12'h200 + 12'(k);
      add(4'b0100, 4'b0100, 12'h203 + 12'(k));
    end
    for (int k = 5; k <= 7; k++) begin
      e_occ[2]  = 4'(7 - k);
      e_dout[2] = 12'h200 + 12'(k);
      add(4'b0000, 4'b0100, 12'h000);
    end

    // rotating one-hot push, then pop all four at once
    e_occ[0] = 4'd1; add(4'b0001, 4'b0000, 12'h2E3);
    e_occ[1] = 4'd1; add(4'b0010, 4'b0000, 12'hCF3);
    e_occ[2] = 4'd1; add(4'b0100, 4'b0000, 12'h831);
    e_occ[3] = 4'd1; add(4'b1000, 4'b0000, 12'h7BD);
    e_occ  = '0;
    e_dout = {12'h7BD, 12'h831, 12'hCF3, 12'h2E3};
    add(4'b0000, 4'b1111, 12'h000);

    // broadcast to FIFO0 and FIFO3 at once
    e_occ[0] = 4'd1;
    e_occ[3] = 4'd1;
    add(4'b1001, 4'b0000, 12'h555);
    e_occ     = '0;
    e_dout[0] = 12'h555;
    e_dout[3] = 12'h555;
    add(4'b0000, 4'b1001, 12'h000);

    // ---------------- reset state ----------------
    reset       = 1'b0;
    bus.push    = 4'b0000;
    bus.pop     = 4'b0000;
    bus.data_in = 12'h000;
    z_occ       = '0;
    #12;
    chk_vec(-1, 48'h0, z_occ, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- table ----------------
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      bus.push    = vecs[n].push;
      bus.pop     = vecs[n].pop;
      bus.data_in = vecs[n].din;
      @(posedge clk);
      #1;
      chk_vec(n, vecs[n].dout, vecs[n].occ, vecs[n].err);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    @(negedge clk);
    bus.push    = 4'b0101;
    bus.pop     = 4'b0000;
    bus.data_in = 12'h0F0;
    @(posedge clk);
    #1;
    chk("partial_empty", 1000, 48'(bus.fifo_empty), 48'(4'b1010));
    #2;
    reset    = 1'b0;
    bus.push = 4'b0000;
    #1;
    chk_vec(1001, 48'h0, z_occ, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // first pop after reset is an underflow and is ignored
    @(negedge clk);
    bus.pop = 4'b0001;
    @(posedge clk);
    #1;
    e_tmp = 4'b0001;
    chk_vec(1002, 48'h0, z_occ, e_tmp);
    @(negedge clk);
    bus.pop = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banco_fifos_salida.md
# banco_fifos_salida

Bank of four independent synchronous FIFOs that sits directly downstream of the second-stage arbiter. It captures each arbiter output word into the FIFO selected by the arbiter's one-hot `push` vector. It returns per-FIFO `fifos_almost_full` back-pressure to the arbiter and serves the next stage through per-FIFO `pop` requests with registered read data.

## Interface
- `WORD_SIZE`, 12, width of each data word.
- `FIFO_DEPTH`, 8, entries per FIFO; power of two, at least 4.
- `ALMOST_FULL_LVL`, 6, occupancy at or above which `fifos_almost_full[i]` asserts.
- `ALMOST_EMPTY_LVL`, 1, occupancy at or below which `fifo_almost_empty[i]` asserts.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `push`  input  4  write enable, one bit per FIFO; driven by the arbiter.
- `data_in`  input  WORD_SIZE  write word; the arbiter's `data_out_arb`.
- `pop`  input  4  read request, one bit per FIFO; driven by the downstream stage.
- `data_out`  output  4*WORD_SIZE  registered read data; FIFO i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- `fifo_empty`  output  4  occupancy == 0.
- `fifo_full`  output  4  occupancy == FIFO_DEPTH.
- `fifos_almost_full`  output  4  occupancy >= ALMOST_FULL_LVL; back-pressure to the arbiter.
- `fifo_almost_empty`  output  4  occupancy <= ALMOST_EMPTY_LVL.
- `fifo_error`  output  4  sticky overflow/underflow flag; present only under the configuration macro.

## Operation
- Each FIFO is a circular buffer with:
  - a write pointer and a read pointer, each log2(FIFO_DEPTH) bits; both wrap from FIFO_DEPTH-1 to 0;
  - an occupancy counter of log2(FIFO_DEPTH)+1 bits.
- Write: `push[i]` with FIFO i not full stores `data_in` at the write pointer, then advances the pointer.
  - Several `push` bits set in the same cycle broadcast `data_in` to every selected FIFO.
- Read: `pop[i]` with FIFO i not empty loads the head word into `data_out` slice i, then advances the read pointer.
  - When no read occurs, `data_out` slice i holds its previous value.
- Push and pop on the same FIFO in the same cycle:
  - Both take effect and occupancy is unchanged. This also holds when the FIFO is full.
  - When the FIFO is empty, the pop is ignored (no fall-through) and the push is accepted.
- Overflow: a push on a full FIFO with no pop in the same cycle is dropped. Pointers and memory are unchanged.
- Underflow: a pop on an empty FIFO is ignored and `data_out` slice i holds.
- All flags are decoded combinationally from the registered occupancy.
- The four FIFOs share no state; activity on one never affects another.

## Timing
- Reset (asynchronous on the falling edge of `reset`) clears:
  - all pointers and counters to 0;
  - `data_out` to 0;
  - `fifo_error` to 0.
- Reset values of the flags:
  - `fifo_empty` = 4'b1111
  - `fifo_almost_empty` = 4'b1111
  - `fifo_full` = 0
  - `fifos_almost_full` = 0
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately, without waiting for a clock edge.
- Write-to-flag latency: flags reflect a write from the edge on which it is captured. The arbiter sees `fifos_almost_full` one cycle after the push.
- Read latency: `data_out` is valid one cycle after the edge that samples `pop`, and stays valid until the next accepted pop.
- Minimum write-to-read: a word pushed at edge N can be popped at edge N+1 and appears on `data_out` after edge N+1.

## Configuration
- `BANCO_FIFOS_ERR_EN` defined:
  - `fifo_error[i]` sets on the edge where an overflow or underflow occurs on FIFO i;
  - it remains set until reset.
- Not defined:
  - `fifo_error` is tied to 4'b0000 and no error registers are synthesized;
  - overflow and underflow are still handled as described under Operation.

## Test plan
- Reset, then push FIFO0 eight times with 0x001..0x008 -> `fifos_almost_full[0]` rises after the 6th write edge and `fifo_full[0]` after the 8th; FIFOs 1-3 stay empty.
- Pop FIFO0 eight times -> `data_out[11:0]` shows 0x001..0x008, each one cycle after its pop; after the last pop `fifo_empty[0]`=1 and `data_out` holds 0x008.
- Push to a full FIFO1 with no pop, then pop an empty FIFO3 -> word dropped, occupancy stays 8, and with the macro defined `fifo_error` = 4'b1010 until reset.
- FIFO2 holding 3 words, `push[2]` and `pop[2]` asserted together for 4 cycles -> occupancy stays 3 and the read order matches the write order.
- Rotating one-hot push of 0x2E3, 0xCF3, 0x831, 0x7BD to FIFOs 0-3 -> each FIFO holds exactly its own word; a simultaneous `pop`=4'b1111 returns all four on the next cycle.
- Assert `reset` low between clock edges while the FIFOs are partly full -> all outputs take their reset values immediately, and the first post-reset pop is ignored as an underflow.
